ebi_bridge: RTL

- Parametrised EBI slave bridge; successor to the fixed single-register EBI front end inside display_driver.
- Samples the asynchronous multiplexed EBI bus (AD/ALE/CS/RE/WE) from the MCU and turns writes into buffered {addr,data} transactions on a valid/ready stream.
- Serves MCU reads through a request/acknowledge port with timeout. Drives the AD return path through split output/enable signals.
- Sits between the top-level EBI pins and the display/PPU register fabric.

---
 rtl/ebi_bridge.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/ebi_bridge.sv
// ebi_bridge: EBI slave bridge turning synchronised MCU writes into a buffered
// {addr,data} stream and serving MCU reads through a req/ack port with timeout.
module ebi_bridge #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int DEPTH = 8,
  parameter int SYNC_STAGES = 2,
  parameter int AUTO_INC = 0,
  parameter int RD_TIMEOUT = 64,
  parameter logic [DATA_W-1:0] RD_DEFAULT = 16'hDEAD
) (
  input  logic              clk_100m,
  input  logic              btn_rst,
  input  logic [DATA_W-1:0] ebi_ad_i,
  output logic [DATA_W-1:0] ebi_ad_o,
  output logic              ebi_ad_oe,
  input  logic              ebi_ale,
  input  logic              ebi_cs,
  input  logic              ebi_re,
  input  logic              ebi_we,
  output logic              wr_valid,
  input  logic              wr_ready,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              rd_req,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_ack,
  input  logic [DATA_W-1:0] rd_data,
  output logic              overflow,
  output logic [7:0]        drop_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(RD_TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, DRAIN, REQ, HOLD} state_t;
  state_t state_q;
  logic [3:0] st_q [SYNC_STAGES];
  logic [DATA_W-1:0] ad_q [SYNC_STAGES];
  logic [3:0] prev_q, s;
  logic [DATA_W-1:0] ad_s;
  logic [ADDR_W+DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0] cnt_q;
  logic [ADDR_W-1:0] addr_q, wr_addr_q, rd_addr_q;
  logic [DATA_W-1:0] wr_data_q, ad_o_q;
  logic [TW-1:0] tmr_q;
  logic [7:0] drop_q;
  logic wr_valid_q, rd_req_q, oe_q, ovf_q;
  logic ale_fall, cs_rise, re_fall, push, pop, full, accept, load, fifo_empty, rd_done;
  // strobe vector order is {ale, cs, re, we}; all strobes are active-low
  assign s = st_q[SYNC_STAGES-1];
  assign ad_s = ad_q[SYNC_STAGES-1];
  assign ale_fall = prev_q[3] & ~s[3] & ~s[2];
  assign cs_rise = ~prev_q[2] & s[2];
  assign re_fall = prev_q[1] & ~s[1] & ~s[2];
  assign push = ~prev_q[0] & s[0] & ~s[2];
  assign pop = wr_valid_q & wr_ready;
  assign full = (cnt_q + {{AW{1'b0}}, wr_valid_q}) == (AW+1)'(DEPTH);
  assign accept = push & (~full | pop);
  // the head register only ever reloads from storage, so a push never falls through
  assign load = (cnt_q != '0) & (~wr_valid_q | pop);
  assign fifo_empty = (cnt_q == '0) & ~wr_valid_q & ~push;
  assign rd_done = (state_q == HOLD) & s[1] & ~cs_rise;
  assign wr_valid = wr_valid_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign rd_req = rd_req_q;
  assign rd_addr = rd_addr_q;
  assign ebi_ad_oe = oe_q;
  assign ebi_ad_o = ad_o_q;
  assign overflow = ovf_q;
  assign drop_cnt = drop_q;
  always_ff @(posedge clk_100m) begin
    if (!btn_rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        st_q[i] <= '1;
        ad_q[i] <= '0;
      end
      prev_q <= '1;
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q <= '0;
      wr_valid_q <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      addr_q <= '0;
      ovf_q <= 1'b0;
      drop_q <= '0;
      state_q <= IDLE;
      rd_req_q <= 1'b0;
      rd_addr_q <= '0;
      oe_q <= 1'b0;
      ad_o_q <= '0;
      tmr_q <= '0;
    end else begin
      st_q[0] <= {ebi_ale, ebi_cs, ebi_re, ebi_we};
      ad_q[0] <= ebi_ad_i;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        st_q[i] <= st_q[i-1];
        ad_q[i] <= ad_q[i-1];
      end
      prev_q <= s;
      if (accept) begin
        mem_q[wptr_q] <= {addr_q, ad_s};
        wptr_q <= wptr_q + 1'b1;
      end
      if (load) begin
        {wr_addr_q, wr_data_q} <= mem_q[rptr_q];
        rptr_q <= rptr_q + 1'b1;
      end
      wr_valid_q <= load | (wr_valid_q & ~wr_ready);
      cnt_q <= cnt_q + {{AW{1'b0}}, accept} - {{AW{1'b0}}, load};
      if (push & full & ~pop) begin
        ovf_q <= 1'b1;
        drop_q <= (drop_q == 8'hFF) ? drop_q : drop_q + 8'd1;
      end
      if (ale_fall) addr_q <= ad_s[ADDR_W-1:0];
      else if (AUTO_INC != 0 && (push || rd_done)) addr_q <= addr_q + 1'b1;
      if (cs_rise) begin
        state_q <= IDLE;
        rd_req_q <= 1'b0;
        oe_q <= 1'b0;
        ad_o_q <= '0;
      end else begin
        case (state_q)
          IDLE: if (re_fall) state_q <= DRAIN;
          DRAIN: if (fifo_empty) begin
            state_q <= REQ;
            rd_req_q <= 1'b1;
            rd_addr_q <= addr_q;
            tmr_q <= '0;
          end
          REQ: if (rd_ack || tmr_q == TW'(RD_TIMEOUT - 1)) begin
            state_q <= HOLD;
            rd_req_q <= 1'b0;
            oe_q <= ~s[1];
            ad_o_q <= rd_ack ? rd_data : RD_DEFAULT;
          end else tmr_q <= tmr_q + 1'b1;
          default: if (s[1]) begin
            state_q <= IDLE;
            oe_q <= 1'b0;
            ad_o_q <= '0;
          end
        endcase
      end
    end
  end
endmodule
